// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the adder datapath and its result FIFO.
//   DEFAULT_WIDTH : adder operand width; every sum carries one extra carry bit
//   DEFAULT_DEPTH : number of result entries buffered by sum_result_fifo
//   COUNT_W       : width of an occupancy count that can reach DEFAULT_DEPTH
//   sum_t         : one adder result, operand width plus carry
// ----------------------------------------------------------------------------
package adder_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 8;
   localparam int COUNT_W       = $clog2(DEFAULT_DEPTH) + 1;

   typedef logic [DEFAULT_WIDTH:0] sum_t;

endpackage

// File: rtl/sum_fifo_mem.sv
// ----------------------------------------------------------------------------
// sum_fifo_mem
// Storage array for sum_result_fifo: DEPTH entries of WIDTH+1 bits.
// Ports:
//   clock : write clock
//   we    : write enable, the entry at waddr takes wdata on the rising edge
//   waddr : write address
//   wdata : data to store
//   raddr : read address
//   rdata : contents of the entry at raddr, read combinationally
// The array is never reset; the FIFO control logic decides which entries are
// meaningful.
// ----------------------------------------------------------------------------
module sum_fifo_mem
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                       clock,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [WIDTH:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [WIDTH:0]             rdata
);

   logic [WIDTH:0] memArray [DEPTH];

   // Single synchronous write port; no reset so the array maps onto plain
   // register files or distributed RAM.
   always_ff @(posedge clock) begin
      if (we) begin
         memArray[waddr] <= wdata;
      end
   end

   // Asynchronous read gives the FIFO its show-ahead head without a cycle of
   // read latency.
   assign rdata = memArray[raddr];

endmodule

// File: rtl/sum_result_fifo.sv
// ----------------------------------------------------------------------------
// sum_result_fifo
// Show-ahead FIFO that buffers adder results until a consumer takes them.
// Ports:
//   clock      : single clock, all state changes on the rising edge
//   reset      : synchronous active-high reset, wins over any transfer
//   sum_in     : adder result (WIDTH+1 bits, carry in the MSB)
//   sum_valid  : push request for sum_in
//   pop_ready  : consumer takes dout this cycle
//   dout       : oldest stored entry, zero when empty
//   dout_valid : dout holds a real entry
//   full       : DEPTH entries stored
//   empty      : no entries stored
//   count      : number of stored entries
//   overflow   : sticky, a sum was dropped because the FIFO was full
// ----------------------------------------------------------------------------
module sum_result_fifo
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [WIDTH:0]           sum_in,
   input  logic                     sum_valid,
   input  logic                     pop_ready,
   output logic [WIDTH:0]           dout,
   output logic                     dout_valid,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]  rdPtr_q, rdPtr_d;
   logic [AW-1:0]  wrPtr_q, wrPtr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           full_q, full_d;
   logic           empty_q, empty_d;
   logic           overflow_q, overflow_d;
   logic           doPush;
   logic           doPop;
   logic [WIDTH:0] memRdata;

   // Next-state logic. A pop frees the head slot on the same edge, so a push
   // into a full FIFO is accepted when it is paired with a pop. Pointers are
   // log2(DEPTH) bits wide and simply wrap; count carries one extra bit so it
   // can represent DEPTH, and the flags are derived from the next count so
   // they always agree with the registered count.
   always_comb begin
      doPop      = ~empty_q & pop_ready;
      doPush     = sum_valid & (~full_q | doPop);
      rdPtr_d    = rdPtr_q;
      wrPtr_d    = wrPtr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (sum_valid & full_q & ~doPop);

      if (doPush) begin
         wrPtr_d = wrPtr_q + AW'(1);
      end
      if (doPop) begin
         rdPtr_d = rdPtr_q + AW'(1);
      end

      case ({doPush, doPop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   // State registers. Reset returns the FIFO to empty and clears the sticky
   // overflow; any transfer requested in the same cycle is lost.
   always_ff @(posedge clock) begin
      if (reset) begin
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         rdPtr_q    <= rdPtr_d;
         wrPtr_q    <= wrPtr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
      end
   end

   // The write is gated by reset so a push coinciding with reset leaves no
   // trace, even in the storage array.
   sum_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) uMem (
      .clock (clock),
      .we    (doPush & ~reset),
      .waddr (wrPtr_q),
      .wdata (sum_in),
      .raddr (rdPtr_q),
      .rdata (memRdata)
   );

   // Head entry is masked to zero while empty so stale storage never leaks.
   assign dout       = empty_q ? '0 : memRdata;
   assign dout_valid = ~empty_q;
   assign full       = full_q;
   assign empty      = empty_q;
   assign count      = count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_sum_result_fifo.sv
// ----------------------------------------------------------------------------
// tb_sum_result_fifo
// Scoreboard bench for sum_result_fifo (WIDTH=8, DEPTH=8). The driver pushes
// every sum it expects the FIFO to accept into a queue; a monitor compares
// each popped dout with the queue head. Occupancy flags are checked against
// hand-computed constants after each directed step.
// ----------------------------------------------------------------------------
module tb_sum_result_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;

   logic         clock;
   logic         reset;
   logic [WIDTH:0] sum_in;
   logic         sum_valid;
   logic         pop_ready;
   logic [WIDTH:0] dout;
   logic         dout_valid;
   logic         full;
   logic         empty;
   logic [3:0]   count;
   logic         overflow;

   int           assertCount = 0;
   int           failCount   = 0;
   int           modelCount  = 0;
   logic [WIDTH:0] expQ [$];

   sum_result_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .sum_in     (sum_in),
      .sum_valid  (sum_valid),
      .pop_ready  (pop_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .overflow   (overflow)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Drive one cycle of inputs, record accepted pushes in the scoreboard,
   // then wait for the edge and settle just after it.
   task automatic applyStimulus(input logic v, input logic [WIDTH:0] d,
                                input logic pr, input logic rst);
      int  newCount;
      bit  mPop;
      bit  mPush;
      sum_valid = v;
      sum_in    = d;
      pop_ready = pr;
      reset     = rst;
      if (rst) begin
         newCount = 0;
         expQ.delete();
      end else begin
         mPop  = (modelCount > 0) && pr;
         mPush = v && ((modelCount < DEPTH) || mPop);
         if (mPush) expQ.push_back(d);
         newCount = modelCount + int'(mPush) - int'(mPop);
      end
      @(posedge clock);
      #1;
      modelCount = newCount;
   endtask

   // Compare the occupancy outputs with hand-computed values.
   task automatic checkOutput(input string name, input int expCount,
                              input logic expFull, input logic expEmpty,
                              input logic expOvf);
      assertCount++;
      if (int'(count) != expCount) begin
         failCount++;
         $display("[TB] FAIL %s.count: got %0d, expected %0d", name, count, expCount);
      end
      assertCount++;
      if (full !== expFull) begin
         failCount++;
         $display("[TB] FAIL %s.full: got %b, expected %b", name, full, expFull);
      end
      assertCount++;
      if (empty !== expEmpty) begin
         failCount++;
         $display("[TB] FAIL %s.empty: got %b, expected %b", name, empty, expEmpty);
      end
      assertCount++;
      if (dout_valid !== ~expEmpty) begin
         failCount++;
         $display("[TB] FAIL %s.dout_valid: got %b, expected %b", name, dout_valid, ~expEmpty);
      end
      assertCount++;
      if (overflow !== expOvf) begin
         failCount++;
         $display("[TB] FAIL %s.overflow: got %b, expected %b", name, overflow, expOvf);
      end
   endtask

   task automatic checkDout(input string name, input logic [WIDTH:0] expDout);
      assertCount++;
      if (dout !== expDout) begin
         failCount++;
         $display("[TB] FAIL %s.dout: got %h, expected %h", name, dout, expDout);
      end
   endtask

   // Every expected sum must have come out by now.
   task automatic checkDrained(input string name);
      assertCount++;
      if (expQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL %s.pending: got %0d unread entries, expected 0", name, expQ.size());
      end
   endtask

   // Monitor: inputs are stable at the falling edge, so a pop about to happen
   // on the next rising edge is visible here; compare dout with the oldest
   // expected sum.
   initial begin
      logic [WIDTH:0] expVal;
      forever begin
         @(negedge clock);
         if (reset === 1'b0 && dout_valid === 1'b1 && pop_ready === 1'b1) begin
            assertCount++;
            if (expQ.size() == 0) begin
               failCount++;
               $display("[TB] FAIL popData: got %h, expected no entry", dout);
            end else begin
               expVal = expQ.pop_front();
               if (dout !== expVal) begin
                  failCount++;
                  $display("[TB] FAIL popData: got %h, expected %h", dout, expVal);
               end
            end
         end
      end
   end

   initial begin
      sum_valid = 1'b0;
      sum_in    = '0;
      pop_ready = 1'b0;
      reset     = 1'b1;

      $display("[TB] reset");
      applyStimulus(1'b0, 9'h000, 1'b0, 1'b1);
      checkOutput("reset", 0, 1'b0, 1'b1, 1'b0);
      checkDout("reset", 9'h000);

      $display("[TB] three pushes then drain");
      applyStimulus(1'b1, 9'h1FF, 1'b0, 1'b0);
      applyStimulus(1'b1, 9'h000, 1'b0, 1'b0);
      applyStimulus(1'b1, 9'h155, 1'b0, 1'b0);
      checkOutput("threePush", 3, 1'b0, 1'b0, 1'b0);
      checkDout("threePushHead", 9'h1FF);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
      checkOutput("threeDrained", 0, 1'b0, 1'b1, 1'b0);
      checkDout("threeDrained", 9'h000);
      checkDrained("threeDrained");

      $display("[TB] pop while empty");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
         checkOutput("popWhileEmpty", 0, 1'b0, 1'b1, 1'b0);
      end

      $display("[TB] fill, push with pop when full, overflow");
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 9'(9'h101 + i), 1'b0, 1'b0);
      checkOutput("fill", 8, 1'b1, 1'b0, 1'b0);
      checkDout("fillHead", 9'h101);
      applyStimulus(1'b1, 9'h0AA, 1'b1, 1'b0);
      checkOutput("fullPushPop", 8, 1'b1, 1'b0, 1'b0);
      checkDout("fullPushPopHead", 9'h102);
      applyStimulus(1'b1, 9'h0EE, 1'b0, 1'b0);
      checkOutput("overflow", 8, 1'b1, 1'b0, 1'b1);
      checkDout("overflowHead", 9'h102);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
      checkOutput("drainAfterOverflow", 0, 1'b0, 1'b1, 1'b1);
      checkDrained("drainAfterOverflow");

      $display("[TB] reset with five entries and overflow set");
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 9'(9'h050 + i), 1'b0, 1'b0);
      checkOutput("fiveStored", 5, 1'b0, 1'b0, 1'b1);
      checkDout("fiveStoredHead", 9'h050);
      applyStimulus(1'b1, 9'h1AB, 1'b1, 1'b1);
      checkOutput("resetMidOp", 0, 1'b0, 1'b1, 1'b0);
      checkDout("resetMidOp", 9'h000);
      applyStimulus(1'b0, 9'h000, 1'b0, 1'b0);
      checkOutput("afterReset", 0, 1'b0, 1'b1, 1'b0);

      $display("[TB] streaming push and pop across pointer wrap");
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 9'(9'h0F0 + i * 13), 1'b1, 1'b0);
      checkOutput("streamSteady", 1, 1'b0, 1'b0, 1'b0);
      checkDout("streamLast", 9'(9'h0F0 + 19 * 13));
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 9'h000, 1'b1, 1'b0);
      checkOutput("streamDrained", 0, 1'b0, 1'b1, 1'b0);
      checkDrained("streamDrained");

      sum_valid = 1'b0;
      pop_ready = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
